// File: rtl/pc_fetch_unit.sv
// Program-counter stage: next-PC selection, RUN/HALT(/FAULT) fetch control and a retired-fetch counter.
// Optional address checking is enabled by defining PC_FAULT_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 128,
  parameter int          CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic             stall,
  input  logic             halt,
  input  logic [1:0]       PCSrc,
  input  logic [15:0]      Immediate,
  input  logic [25:0]      j_addr,
  input  logic [31:0]      rsData,
  output logic [31:0]      pc,
  output logic [31:0]      pcPlus4,
  output logic             InsMemRW,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] fetchCount,
  output logic [1:0]       state_dbg
);

`ifdef PC_FAULT_CHECK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam logic [31:0] PC_LIMIT = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc_target, pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             addr_bad;

  assign pcPlus4 = pc + 32'd4;

  always_comb begin
    pc_target = pcPlus4;
    case (PCSrc)
      2'b00: pc_target = pcPlus4;
      2'b01: pc_target = pcPlus4 + {{14{Immediate[15]}}, Immediate, 2'b00};
      2'b10: pc_target = rsData;
      2'b11: pc_target = {pcPlus4[31:28], j_addr, 2'b00};
      default: pc_target = pcPlus4;
    endcase
  end

  // Misaligned or past the last instruction word of the memory.
  assign addr_bad = (pc_target[1:0] != 2'b00) || (pc_target > PC_LIMIT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = fetchCount;
    case (state)
      ST_RUN: begin
        if (halt) begin
          state_nxt = ST_HALT;
        end else if (!stall && PCWre) begin
          if (FAULT_EN && addr_bad) begin
            state_nxt = ST_FAULT;
          end else begin
            pc_nxt  = pc_target;
            cnt_nxt = fetchCount + 1'b1;
          end
        end
      end
      ST_HALT:  state_nxt = ST_HALT;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      fetchCount <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fetchCount <= cnt_nxt;
    end
  end

  assign InsMemRW  = (state != ST_RUN);
  assign halted    = (state == ST_HALT);
  assign fault     = FAULT_EN && (state == ST_FAULT);
  assign state_dbg = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: each step pushes its expected outputs and checks them one edge later.
module tb_pc_fetch_unit;
  localparam int W = 51;  // {pc[31:0], fetchCount[15:0], InsMemRW, halted, fault}

  logic        CLK = 1'b0;
  logic        Reset = 1'b0, PCWre = 1'b0, stall = 1'b0, halt = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [15:0] Immediate = '0;
  logic [25:0] j_addr = '0;
  logic [31:0] rsData = '0;
  logic [31:0] pc, pcPlus4;
  logic        InsMemRW, halted, fault;
  logic [15:0] fetchCount;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  pc_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(128), .CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .stall(stall), .halt(halt),
    .PCSrc(PCSrc), .Immediate(Immediate), .j_addr(j_addr), .rsData(rsData),
    .pc(pc), .pcPlus4(pcPlus4), .InsMemRW(InsMemRW), .halted(halted),
    .fault(fault), .fetchCount(fetchCount), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, record the expectation, clock, then compare.
  task automatic step(input logic rst, input logic we, input logic st, input logic hl,
                      input logic [1:0] src, input logic [15:0] imm, input logic [25:0] ja,
                      input logic [31:0] rs, input logic [31:0] e_pc, input logic [15:0] e_cnt,
                      input logic e_rw, input logic e_h, input logic e_f);
    logic [W-1:0] e;
    Reset = rst; PCWre = we; stall = st; halt = hl;
    PCSrc = src; Immediate = imm; j_addr = ja; rsData = rs;
    exp_q.push_back({e_pc, e_cnt, e_rw, e_h, e_f});
    @(posedge CLK);
    #1;
    total++;
    assert (exp_q.size() > 0) else begin
      bad++;
      $error("FAIL queue_empty observed=0 expected=1");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("pc",         pc,                   e[50:19]);
      cmp("pcPlus4",    pcPlus4,              e[50:19] + 32'd4);
      cmp("fetchCount", {16'h0, fetchCount},  {16'h0, e[18:3]});
      cmp("InsMemRW",   {31'h0, InsMemRW},    {31'h0, e[2]});
      cmp("halted",     {31'h0, halted},      {31'h0, e[1]});
      cmp("fault",      {31'h0, fault},       {31'h0, e[0]});
    end
  endtask

  initial begin
    // reset, with PCWre asserted to show reset dominates
    step(1, 1, 0, 0, 2'b00, 0, 0, 0, 32'h0, 16'd0, 0, 0, 0);
    // sequential fetch
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'h4, 16'd1, 0, 0, 0);
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'h8, 16'd2, 0, 0, 0);
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'hC, 16'd3, 0, 0, 0);
    // PCWre low holds
    step(0, 0, 0, 0, 2'b11, 0, 26'h10, 0, 32'hC, 16'd3, 0, 0, 0);
    // branches from pc=8
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 16'd0, 0, 0, 0);
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'h4, 16'd1, 0, 0, 0);
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'h8, 16'd2, 0, 0, 0);
    step(0, 1, 0, 0, 2'b01, 16'hFFFE, 0, 0, 32'h4, 16'd3, 0, 0, 0);
    step(0, 1, 0, 0, 2'b01, 16'h0003, 0, 0, 32'h14, 16'd4, 0, 0, 0);
    // jump and jr
    step(0, 1, 0, 0, 2'b11, 0, 26'h10, 0, 32'h40, 16'd5, 0, 0, 0);
    step(0, 1, 0, 0, 2'b10, 0, 0, 32'h1C, 32'h1C, 16'd6, 0, 0, 0);
    step(0, 1, 0, 0, 2'b10, 0, 0, 32'hC, 32'hC, 16'd7, 0, 0, 0);
    // stall overrides PCWre
    step(0, 1, 1, 0, 2'b00, 0, 0, 0, 32'hC, 16'd7, 0, 0, 0);
    step(0, 1, 1, 0, 2'b00, 0, 0, 0, 32'hC, 16'd7, 0, 0, 0);
    // halt with PCWre: halt wins, pc stays on the halt instruction
    step(0, 1, 0, 1, 2'b00, 0, 0, 0, 32'hC, 16'd7, 1, 1, 0);
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'hC, 16'd7, 1, 1, 0);
    step(0, 1, 0, 0, 2'b10, 0, 0, 32'h20, 32'hC, 16'd7, 1, 1, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 16'd0, 0, 0, 0);
`ifdef PC_FAULT_CHECK_EN
    // misaligned target faults, pc and count unchanged
    step(0, 1, 0, 0, 2'b10, 0, 0, 32'h6, 32'h0, 16'd0, 1, 0, 1);
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'h0, 16'd0, 1, 0, 1);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 16'd0, 0, 0, 0);
    // last valid word loads, one past the end faults
    step(0, 1, 0, 0, 2'b10, 0, 0, 32'h7C, 32'h7C, 16'd1, 0, 0, 0);
    step(0, 1, 0, 0, 2'b10, 0, 0, 32'h80, 32'h7C, 16'd1, 1, 0, 1);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 16'd0, 0, 0, 0);
`else
    // no checking: any target loads
    step(0, 1, 0, 0, 2'b10, 0, 0, 32'h6, 32'h6, 16'd1, 0, 0, 0);
    step(0, 1, 0, 0, 2'b10, 0, 0, 32'h80, 32'h80, 16'd2, 0, 0, 0);
    // 32-bit wrap and jump keeps pcPlus4[31:28]
    step(0, 1, 0, 0, 2'b10, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 16'd3, 0, 0, 0);
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'h0, 16'd4, 0, 0, 0);
    step(0, 1, 0, 0, 2'b10, 0, 0, 32'h7000_0000, 32'h7000_0000, 16'd5, 0, 0, 0);
    step(0, 1, 0, 0, 2'b11, 0, 26'h1, 0, 32'h7000_0004, 16'd6, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 16'd0, 0, 0, 0);
`endif
    // reset mid-RUN beats a pending jump
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'h4, 16'd1, 0, 0, 0);
    step(1, 1, 0, 0, 2'b11, 0, 26'h10, 0, 32'h0, 16'd0, 0, 0, 0);
    step(0, 1, 0, 0, 2'b11, 0, 26'h10, 0, 32'h40, 16'd1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
